// File: rtl/hsi_s_rx_ctrl.sv
// Purpose : slave-side HSI frame receiver; frames decoded bytes as header/payload/CRC16, checks CRC, reports result.
// Latency : payload byte q/q_rdy 1 clk after d_rdy; msg_ok/crc_err/btc_vld 1 clk after the CRC low byte.
// Backpr. : none; the decoder strobes at most one byte per cycle and every strobe is consumed.
//
// Ports   : clk, rst (async, active high), en (0 forces IDLE), d/d_rdy (byte strobe in),
//           q/q_rdy (payload stream out), msg_type (one-hot {CCW,DPR,SR,BTC,TM}), btc/btc_vld,
//           msg_ok, crc_err, hdr_err, tmo_err (one-cycle result pulses),
//           err_cnt (only with HSI_S_RX_ERR_CNT_EN defined: saturating error counter).
module hsi_s_rx_ctrl #(
   parameter int TM_LEN    = 32,
   parameter int BTC_LEN   = 5,
   parameter int SR_LEN    = 0,
   parameter int DPR_LEN   = 0,
   parameter int CCW_LEN   = 1,
   parameter int GAP_TICKS = 2000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [7:0]  d,
   input  logic        d_rdy,
   output logic [7:0]  q,
   output logic        q_rdy,
   output logic [4:0]  msg_type,
   output logic [39:0] btc,
   output logic        btc_vld,
   output logic        msg_ok,
   output logic        crc_err,
   output logic        hdr_err,
`ifdef HSI_S_RX_ERR_CNT_EN
   output logic        tmo_err,
   output logic [15:0] err_cnt
`else
   output logic        tmo_err
`endif
);

   localparam int GW = $clog2(GAP_TICKS + 1);

   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_CRC_HI, S_CRC_LO} state_t;

   // CRC16-CCITT, poly 0x1021, MSB-first, one byte per call
   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = 7; i >= 0; i--) begin
         fb = r[15] ^ b[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction

   state_t        state, state_nxt;
   logic [15:0]   crc, crc_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [7:0]    crc_hi, crc_hi_nxt;
   logic [39:0]   shadow, shadow_nxt;
   logic [GW-1:0] gap, gap_nxt;
   logic [7:0]    q_nxt;
   logic          q_rdy_nxt;
   logic [4:0]    type_nxt;
   logic [39:0]   btc_nxt;
   logic          btc_vld_nxt, ok_nxt, crc_err_nxt, hdr_err_nxt, tmo_err_nxt;

   logic          hdr_vld;
   logic [4:0]    hdr_type;
   logic [7:0]    hdr_len;

   always_comb begin
      hdr_vld  = 1'b1;
      hdr_type = 5'b00000;
      hdr_len  = 8'd0;
      case (d)
         8'h01:   begin hdr_type = 5'b00001; hdr_len = 8'(TM_LEN);  end
         8'h02:   begin hdr_type = 5'b00010; hdr_len = 8'(BTC_LEN); end
         8'h03:   begin hdr_type = 5'b00100; hdr_len = 8'(SR_LEN);  end
         8'h04:   begin hdr_type = 5'b01000; hdr_len = 8'(DPR_LEN); end
         8'h05:   begin hdr_type = 5'b10000; hdr_len = 8'(CCW_LEN); end
         default: hdr_vld = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      crc_nxt     = crc;
      cnt_nxt     = cnt;
      crc_hi_nxt  = crc_hi;
      shadow_nxt  = shadow;
      gap_nxt     = gap;
      q_nxt       = q;
      q_rdy_nxt   = 1'b0;
      type_nxt    = msg_type;
      btc_nxt     = btc;
      btc_vld_nxt = 1'b0;
      ok_nxt      = 1'b0;
      crc_err_nxt = 1'b0;
      hdr_err_nxt = 1'b0;
      tmo_err_nxt = 1'b0;

      if (!en) begin
         // abort silently: no result pulse for a dropped frame
         state_nxt = S_IDLE;
         type_nxt  = 5'b00000;
         gap_nxt   = '0;
         crc_nxt   = 16'hFFFF;
      end else if (d_rdy) begin
         // a byte always wins over a coincident timeout
         gap_nxt = '0;
         case (state)
            S_IDLE: begin
               if (hdr_vld) begin
                  type_nxt   = hdr_type;
                  crc_nxt    = crc_upd(16'hFFFF, d);
                  cnt_nxt    = hdr_len;
                  shadow_nxt = '0;
                  state_nxt  = (hdr_len == 8'd0) ? S_CRC_HI : S_PAYLOAD;
               end else begin
                  hdr_err_nxt = 1'b1;
               end
            end
            S_PAYLOAD: begin
               q_nxt     = d;
               q_rdy_nxt = 1'b1;
               crc_nxt   = crc_upd(crc, d);
               cnt_nxt   = cnt - 8'd1;
               if (msg_type[1]) shadow_nxt = {shadow[31:0], d};
               if (cnt == 8'd1) state_nxt = S_CRC_HI;
            end
            S_CRC_HI: begin
               crc_hi_nxt = d;
               state_nxt  = S_CRC_LO;
            end
            S_CRC_LO: begin
               state_nxt = S_IDLE;
               type_nxt  = 5'b00000;
               crc_nxt   = 16'hFFFF;
               if ({crc_hi, d} == crc) begin
                  ok_nxt = 1'b1;
                  if (msg_type[1]) begin
                     btc_nxt     = shadow;
                     btc_vld_nxt = 1'b1;
                  end
               end else begin
                  crc_err_nxt = 1'b1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end else if (state != S_IDLE) begin
         // counter reaches GAP_TICKS-1 on this edge -> abort the frame
         if (gap == GW'(GAP_TICKS - 2)) begin
            tmo_err_nxt = 1'b1;
            state_nxt   = S_IDLE;
            type_nxt    = 5'b00000;
            gap_nxt     = '0;
            crc_nxt     = 16'hFFFF;
         end else begin
            gap_nxt = gap + GW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         crc      <= 16'hFFFF;
         cnt      <= 8'd0;
         crc_hi   <= 8'd0;
         shadow   <= 40'd0;
         gap      <= '0;
         q        <= 8'd0;
         q_rdy    <= 1'b0;
         msg_type <= 5'b00000;
         btc      <= 40'd0;
         btc_vld  <= 1'b0;
         msg_ok   <= 1'b0;
         crc_err  <= 1'b0;
         hdr_err  <= 1'b0;
         tmo_err  <= 1'b0;
      end else begin
         state    <= state_nxt;
         crc      <= crc_nxt;
         cnt      <= cnt_nxt;
         crc_hi   <= crc_hi_nxt;
         shadow   <= shadow_nxt;
         gap      <= gap_nxt;
         q        <= q_nxt;
         q_rdy    <= q_rdy_nxt;
         msg_type <= type_nxt;
         btc      <= btc_nxt;
         btc_vld  <= btc_vld_nxt;
         msg_ok   <= ok_nxt;
         crc_err  <= crc_err_nxt;
         hdr_err  <= hdr_err_nxt;
         tmo_err  <= tmo_err_nxt;
      end
   end

`ifdef HSI_S_RX_ERR_CNT_EN
   // counts on the same edge that raises the error pulse, so it is coincident with it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= 16'd0;
      end else if ((crc_err_nxt | hdr_err_nxt | tmo_err_nxt) && (err_cnt != 16'hFFFF)) begin
         err_cnt <= err_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hsi_s_rx_ctrl.sv
// Purpose : directed, table-driven bench for hsi_s_rx_ctrl plus hand-written multi-cycle sequences.
// Latency : outputs sampled 1 time unit after each rising clk edge.
// Backpr. : none; bench drives one byte strobe per cycle.
module tb_hsi_s_rx_ctrl;

   localparam int G = 2000;

   logic        clk = 1'b0;
   logic        rst, en, d_rdy;
   logic [7:0]  d;
   logic [7:0]  q;
   logic        q_rdy, btc_vld, msg_ok, crc_err, hdr_err, tmo_err;
   logic [4:0]  msg_type;
   logic [39:0] btc;
`ifdef HSI_S_RX_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   hsi_s_rx_ctrl #(.GAP_TICKS(G)) dut (
      .clk(clk), .rst(rst), .en(en), .d(d), .d_rdy(d_rdy),
      .q(q), .q_rdy(q_rdy), .msg_type(msg_type), .btc(btc), .btc_vld(btc_vld),
      .msg_ok(msg_ok), .crc_err(crc_err), .hdr_err(hdr_err),
`ifdef HSI_S_RX_ERR_CNT_EN
      .tmo_err(tmo_err), .err_cnt(err_cnt)
`else
      .tmo_err(tmo_err)
`endif
   );

   typedef struct {
      string      nm;
      logic       en;
      logic       d_rdy;
      logic [7:0] d;
      logic       q_rdy;
      logic [7:0] q;
      logic [4:0] mtype;
      logic [3:0] res;   // {msg_ok, crc_err, hdr_err, tmo_err}
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] tb_crc(input logic [15:0] c, input logic [7:0] b);
      logic [15:0] x;
      x = c ^ {b, 8'h00};
      for (int k = 0; k < 8; k++) x = x[15] ? ((x << 1) ^ 16'h1021) : (x << 1);
      return x;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input string nm, input logic e, input logic r, input logic [7:0] db,
                      input logic qr, input logic [7:0] qb, input logic [4:0] mt, input logic [3:0] res);
      vec_t v;
      v.nm = nm; v.en = e; v.d_rdy = r; v.d = db;
      v.q_rdy = qr; v.q = qb; v.mtype = mt; v.res = res;
      vecs.push_back(v);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] c, sr_crc, ccw_crc, btc_crc, btc2_crc;
      logic [7:0]  s[9];
      logic [7:0]  pl[5];
      logic [7:0]  pl2[5];
      logic        acc;
      int          n;

      s   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      pl  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      pl2 = '{8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};

      // CRC engine reference check
      c = 16'hFFFF;
      for (int i = 0; i < 9; i++) c = tb_crc(c, s[i]);
      chk("crc_123456789", 64'(c), 64'h29B1);

      sr_crc  = tb_crc(16'hFFFF, 8'h03);
      ccw_crc = tb_crc(tb_crc(16'hFFFF, 8'h05), 8'hA5);
      btc_crc = tb_crc(16'hFFFF, 8'h02);
      for (int i = 0; i < 5; i++) btc_crc = tb_crc(btc_crc, pl[i]);
      btc2_crc = tb_crc(16'hFFFF, 8'h02);
      for (int i = 0; i < 5; i++) btc2_crc = tb_crc(btc2_crc, pl2[i]);

      //   name            en r  d                     q_rdy q      type      ok/ce/he/te
      add("sr_hdr",        1, 1, 8'h03,                0, 8'h00, 5'b00100, 4'b0000);
      add("sr_crc_hi",     1, 1, sr_crc[15:8],         0, 8'h00, 5'b00100, 4'b0000);
      add("sr_crc_lo",     1, 1, sr_crc[7:0],          0, 8'h00, 5'b00000, 4'b1000);
      add("idle_quiet",    1, 0, 8'h00,                0, 8'h00, 5'b00000, 4'b0000);
      add("hdr_07",        1, 1, 8'h07,                0, 8'h00, 5'b00000, 4'b0010);
      add("ccw_hdr",       1, 1, 8'h05,                0, 8'h00, 5'b10000, 4'b0000);
      add("ccw_pl",        1, 1, 8'hA5,                1, 8'hA5, 5'b10000, 4'b0000);
      add("ccw_bubble",    1, 0, 8'h00,                0, 8'hA5, 5'b10000, 4'b0000);
      add("ccw_crc_hi",    1, 1, ccw_crc[15:8],        0, 8'hA5, 5'b10000, 4'b0000);
      add("ccw_crc_lo",    1, 1, ccw_crc[7:0],         0, 8'hA5, 5'b00000, 4'b1000);
      add("sr_b2b_hdr",    1, 1, 8'h03,                0, 8'hA5, 5'b00100, 4'b0000);
      add("sr_crc_hi2",    1, 1, sr_crc[15:8],         0, 8'hA5, 5'b00100, 4'b0000);
      add("sr_crc_bad",    1, 1, sr_crc[7:0] ^ 8'h01,  0, 8'hA5, 5'b00000, 4'b0100);
      add("ccw_hdr2",      1, 1, 8'h05,                0, 8'hA5, 5'b10000, 4'b0000);
      add("en_off_drop",   0, 1, 8'hA5,                0, 8'hA5, 5'b00000, 4'b0000);
      add("after_en_off",  1, 1, 8'hA5,                0, 8'hA5, 5'b00000, 4'b0010);
      add("hdr_00",        1, 1, 8'h00,                0, 8'hA5, 5'b00000, 4'b0010);
      add("hdr_06",        1, 1, 8'h06,                0, 8'hA5, 5'b00000, 4'b0010);
      add("tm_hdr",        1, 1, 8'h01,                0, 8'hA5, 5'b00001, 4'b0000);
      add("en_off_idle",   0, 0, 8'h00,                0, 8'hA5, 5'b00000, 4'b0000);

      // reset
      rst = 1'b1; en = 1'b0; d = 8'h00; d_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_state", {5'd0, q, q_rdy, msg_type, btc, btc_vld, msg_ok, crc_err, hdr_err, tmo_err}, 64'd0);
      rst = 1'b0;
      en  = 1'b1;
      step();

      // table-driven vectors, one row per clock
      foreach (vecs[i]) begin
         en = vecs[i].en; d_rdy = vecs[i].d_rdy; d = vecs[i].d;
         step();
         chk(vecs[i].nm, {46'd0, q_rdy, q, msg_type, msg_ok, crc_err, hdr_err, tmo_err},
             {46'd0, vecs[i].q_rdy, vecs[i].q, vecs[i].mtype, vecs[i].res});
      end
      en = 1'b1; d_rdy = 1'b0;
      step();

      // BTC frame with good CRC
      d = 8'h02; d_rdy = 1'b1; step();
      chk("btc_hdr_type", 64'(msg_type), 64'b00010);
      for (int i = 0; i < 5; i++) begin
         d = pl[i]; step();
         chk($sformatf("btc_pl%0d", i), {55'd0, q_rdy, q}, {55'd0, 1'b1, pl[i]});
      end
      d = btc_crc[15:8]; step();
      chk("btc_crc_hi_noq", 64'(q_rdy), 64'd0);
      d = btc_crc[7:0]; step();
      chk("btc_good_pulses", {59'd0, msg_ok, btc_vld, crc_err, msg_type == 5'd0, q_rdy}, 64'b11010);
      chk("btc_value", 64'(btc), 64'h11_2233_4455);
      d_rdy = 1'b0; step();
      chk("btc_vld_one_cycle", {62'd0, btc_vld, msg_ok}, 64'd0);

      // BTC frame with different payload and corrupted CRC low byte: btc must not change
      d = 8'h02; d_rdy = 1'b1; step();
      for (int i = 0; i < 5; i++) begin d = pl2[i]; step(); end
      d = btc2_crc[15:8]; step();
      d = btc2_crc[7:0] ^ 8'h80; step();
      chk("btc_bad_pulses", {61'd0, msg_ok, btc_vld, crc_err}, 64'b001);
      chk("btc_unchanged", 64'(btc), 64'h11_2233_4455);
`ifdef HSI_S_RX_ERR_CNT_EN
      chk("err_cnt_after_crc", 64'(err_cnt), 64'd6);
`endif
      d_rdy = 1'b0; step();

      // TM frame, 3 bytes then silence -> timeout
      d = 8'h01; d_rdy = 1'b1; step();
      d = 8'hA1; step();
      d = 8'hA2; step();
      d = 8'hA3; step();
      d_rdy = 1'b0;
      n = 0;
      while (n < 3 * G && !tmo_err) begin
         step();
         n++;
      end
      chk("tmo_latency", 64'(n), 64'(G - 1));
      chk("tmo_clears_type", 64'(msg_type), 64'd0);
`ifdef HSI_S_RX_ERR_CNT_EN
      chk("err_cnt_after_tmo", 64'(err_cnt), 64'd7);
`endif
      step();
      chk("tmo_one_cycle", 64'(tmo_err), 64'd0);
      d = 8'h02; d_rdy = 1'b1; step();
      chk("hdr_after_tmo", 64'(msg_type), 64'b00010);
      d_rdy = 1'b0;
      en = 1'b0; step();
      en = 1'b1; step();

      // async reset in the middle of a TM frame
      d = 8'h01; d_rdy = 1'b1; step();
      d = 8'hBB; step();
      d = 8'hCC; step();
      d_rdy = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_rst_outputs",
          {5'd0, q, q_rdy, msg_type, btc, btc_vld, msg_ok, crc_err, hdr_err, tmo_err}, 64'd0);
      step();
      rst = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         acc = acc | q_rdy | btc_vld | msg_ok | crc_err | hdr_err | tmo_err;
      end
      chk("no_pulse_after_rst", 64'(acc), 64'd0);

      // CRC state restarts cleanly after reset
      d = 8'h03; d_rdy = 1'b1; step();
      d = sr_crc[15:8]; step();
      d = sr_crc[7:0]; step();
      chk("sr_after_rst", {62'd0, msg_ok, crc_err}, 64'b10);
      d_rdy = 1'b0; step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
